piso_serializer: RTL

- Parallel-in / serial-out shifter that produces a one-bit data stream with a write strobe.
- Drives the d_in / we inputs of the team's single-bit enable registers and serial sinks.
- Accepts a WIDTH-bit word over a valid/ready handshake, then emits one bit per clock, with an optional trailing parity bit.
- A stall input pauses the stream without losing a bit.

---
 rtl/piso_serializer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter with a valid/ready load port and a
// stallable one-bit output stream. It can append an even-parity bit after
// the data bits. A word accepted on the last-bit edge of the current frame
// follows that frame with no idle cycle between them.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             stall,
  output logic             ser_out,
  output logic             ser_we,
  output logic             ser_last,
  output logic             busy
);

  // Number of bits in one frame, including the optional parity bit.
  localparam int FRAME_BITS = WIDTH + PARITY;
  // The counter has room for N-1 and never counts below zero.
  localparam int CNT_W = $clog2(WIDTH + 2);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_PAR  = CNT_W'(PARITY);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic             par_bit;
  logic [CNT_W-1:0] count;
  logic             ser_bit;

  logic in_shift;
  logic at_last;
  logic step;
  logic accept;
  logic advance;

  // Even parity over the whole word; sent as the final bit when enabled.
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  // Bit that leaves the word first, as the serial order selects.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return w[WIDTH-1];
    else                return w[0];
  endfunction

  // Bit that becomes visible after one shift of the current register.
  function automatic logic next_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return w[WIDTH-2];
    else                return w[1];
  endfunction

  // Move the register one place toward its output end.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return {w[WIDTH-2:0], 1'b0};
    else                return {1'b0, w[WIDTH-1:1]};
  endfunction

  assign in_shift = (state == ST_SHIFT);
  assign at_last  = (count == '0);
  // The sink consumes a bit on every unstalled edge while shifting.
  assign step     = in_shift && !stall;
  // A bit is consumed and more bits of the frame remain.
  assign advance  = step && !at_last;

  // The next word can enter while idle, or on the edge that consumes the
  // final bit of the frame, which keeps streams back-to-back.
  assign load_ready = !in_shift || (at_last && !stall);
  assign accept     = load_valid && load_ready;

  assign ser_we   = step;
  assign ser_last = in_shift && at_last;
  assign busy     = in_shift;
  assign ser_out  = ser_bit;

  // Frame state: enter SHIFT on accept, return to IDLE after the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (accept) begin
      state <= ST_SHIFT;
    end else if (step && at_last) begin
      state <= ST_IDLE;
    end
  end

  // Bits still to be emitted after the current one; held under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (accept) begin
      count <= CNT_LOAD;
    end else if (advance) begin
      count <= count - CNT_ONE;
    end
  end

  // Shift register and captured parity; load_data only matters on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      par_bit   <= 1'b0;
    end else if (accept) begin
      shift_reg <= load_data;
      par_bit   <= even_parity(load_data);
    end else if (advance) begin
      shift_reg <= shift_word(shift_reg);
    end
  end

  // Registered serial bit: the first bit appears one cycle after accept.
  // The parity bit follows once only it is left to send. The bit holds
  // while stalled or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_bit <= 1'b0;
    end else if (accept) begin
      ser_bit <= first_bit(load_data);
    end else if (advance) begin
      ser_bit <= (count > CNT_PAR) ? next_bit(shift_reg) : par_bit;
    end
  end

endmodule
